case_2_mul_share_arb: RTL

//  Shares one signed 13s x 5s -> 13-bit multiplier datapath between N_REQ requesters.
//  - Round-robin arbitration.
//  - Valid/ready handshake on every requester and on the single result port.
//  - Two-stage registered pipeline: operand register, then product register.

---
 rtl/case_2_mul_share_pkg.sv | 20 ++
 rtl/case_2_mul_rr_pick.sv | 32 +++
 rtl/case_2_mul_share_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/case_2_mul_share_pkg.sv
// Shared widths and transaction types for the shared 13s x 5s multiplier arbiter.
package case_2_mul_share_pkg;

    localparam int A_W    = 13;
    localparam int B_W    = 5;
    localparam int DOUT_W = 13;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
    } mul_op_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DOUT_W-1:0] data;
    } mul_rsp_t;

endpackage

// File: rtl/case_2_mul_rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr wins.
module case_2_mul_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    always_comb begin
        int             idx;
        logic [ID_W-1:0] sel;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            sel = ID_W'(idx);
            if (!any && req_vec[sel]) begin
                any           = 1'b1;
                grant_oh[sel] = 1'b1;
                grant_idx     = sel;
            end
        end
    end

endmodule

// File: rtl/case_2_mul_share_arb.sv
// Round-robin shared signed multiplier: operand stage S1, product stage S2, valid/ready everywhere.
module case_2_mul_share_arb #(
    parameter int N_REQ  = 4,
    parameter int A_W    = case_2_mul_share_pkg::A_W,
    parameter int B_W    = case_2_mul_share_pkg::B_W,
    parameter int DOUT_W = case_2_mul_share_pkg::DOUT_W,
    parameter int ID_W   = case_2_mul_share_pkg::ID_W,
    parameter int CNT_W  = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DOUT_W-1:0]      rsp_data,
    output logic                   busy,
    output logic [CNT_W-1:0]       ops_done
);

    localparam int P_W = A_W + B_W;

    logic [A_W-1:0] a_slot [N_REQ];
    logic [B_W-1:0] b_slot [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_slot[gi] = req_a[gi*A_W +: A_W];
            assign b_slot[gi] = req_b[gi*B_W +: B_W];
        end
    endgenerate

    logic                  v1_reg;
    logic [ID_W-1:0]       id1_reg;
    logic signed [A_W-1:0] a1_reg;
    logic signed [B_W-1:0] b1_reg;
    logic                  v2_reg;
    logic [ID_W-1:0]       id2_reg;
    logic [DOUT_W-1:0]     p2_reg;
    logic [ID_W-1:0]       ptr_reg;
    logic [ID_W-1:0]       ptr_next;
    logic [CNT_W-1:0]      cnt_reg;

    logic                  adv1;
    logic                  adv2;
    logic                  accept;
    logic                  any_req;
    logic [N_REQ-1:0]      grant_oh;
    logic [ID_W-1:0]       grant_idx;
    logic signed [P_W-1:0] prod_full;

    case_2_mul_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_vec   (req_valid),
        .ptr       (ptr_reg),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    assign adv2   = !v2_reg || rsp_ready;
    assign adv1   = !v1_reg || adv2;
    assign accept = adv1 && any_req && ap_rst_n;

    // Nothing may be granted while reset is held, even though both stages look empty.
    assign req_ready = (adv1 && ap_rst_n) ? grant_oh : '0;

    assign ptr_next  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign prod_full = P_W'(a1_reg) * P_W'(b1_reg);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1_reg  <= 1'b0;
            id1_reg <= '0;
            a1_reg  <= '0;
            b1_reg  <= '0;
            v2_reg  <= 1'b0;
            id2_reg <= '0;
            p2_reg  <= '0;
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else begin
            if (adv1) begin
                v1_reg <= accept;
                if (accept) begin
                    id1_reg <= grant_idx;
                    a1_reg  <= a_slot[grant_idx];
                    b1_reg  <= b_slot[grant_idx];
                    ptr_reg <= ptr_next;
                end
            end
            if (v1_reg && adv2) begin
                v2_reg  <= 1'b1;
                id2_reg <= id1_reg;
                p2_reg  <= prod_full[DOUT_W-1:0];
            end else if (rsp_ready) begin
                v2_reg <= 1'b0;
            end
            if (v2_reg && rsp_ready) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = v2_reg;
    assign rsp_id    = id2_reg;
    assign rsp_data  = p2_reg;
    assign busy      = v1_reg || v2_reg;
    assign ops_done  = cnt_reg;

endmodule
